// File: rtl/fetch_pkg.sv
// Shared definitions for the LEGv8 instruction fetch stage: fetch FSM
// encodings, immediate-format select codes and the opcode fields the
// pre-decoder matches on.
package fetch_pkg;

  // Fetch sequencer states. S_DROP means a response is still owed by the
  // memory but belongs to a fetch that a redirect made stale.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Immediate-format select driven into the sign-extend unit's opCode.
  localparam logic [1:0] EXT_D    = 2'b00;  // LDUR / STUR
  localparam logic [1:0] EXT_CB   = 2'b01;  // CBZ / CBNZ
  localparam logic [1:0] EXT_B    = 2'b10;  // B
  localparam logic [1:0] EXT_NONE = 2'b11;  // no immediate to extend

  // D-format opcodes occupy [31:21].
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB-format opcodes occupy [31:24].
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  // B-format opcode occupies [31:26].
  localparam logic [5:0]  OP_B    = 6'b000101;

endpackage

// File: rtl/instr_predecode.sv
// Combinational immediate-format pre-decoder. Classifies a raw LEGv8 word
// into the select code used by the downstream sign-extend unit.
module instr_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  ext_sel
);

  // Operand fields below bit 21 never influence the format class.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instr[20:0];

  // Widest opcode first; the three opcode fields never overlap in value.
  always_comb begin
    ext_sel = EXT_NONE;
    if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      ext_sel = EXT_D;
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      ext_sel = EXT_CB;
    end else if (instr[31:26] == OP_B) begin
      ext_sel = EXT_B;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// LEGv8 instruction fetch stage: owns the PC, issues one outstanding
// request at a time to instruction memory, and holds the IF/ID register.
//
// Handshakes:
//   imem: a fetch is accepted on a cycle where imem_req & imem_gnt; the
//         response arrives later as a single imem_rvalid pulse with no
//         backpressure. imem_req is only raised while the IF/ID slot is
//         free or being consumed, so a response always has a place to land.
//   id:   id_valid & id_ready is a transfer; while id_valid & !id_ready
//         every id_* output is held and no new fetch is requested.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr,
  output logic [1:0]  id_ext_sel,
  output logic [1:0]  dbg_state
);

  fetch_state_e state;
  logic [63:0]  pc;
  logic [63:0]  fetch_pc;
  logic [1:0]   pre_ext;
  logic         fetch_go;
  logic         load;

  instr_predecode u_predecode (
    .instr   (imem_rdata),
    .ext_sel (pre_ext)
  );

  // Request only while the IF/ID slot will be free by the next edge.
  assign imem_req  = rst_n & (state == S_REQ) & (~id_valid | id_ready);
  assign imem_addr = pc;
  assign fetch_go  = imem_req & imem_gnt;
  // A response is only kept when it answers a live fetch and no redirect
  // lands in the same cycle.
  assign load      = (state == S_WAIT) & imem_rvalid & ~branch_taken;
  assign dbg_state = state;

  // Fetch sequencer, PC and IF/ID register; a redirect overrides all else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      fetch_pc   <= 64'h0;
      id_valid   <= 1'b0;
      id_pc      <= 64'h0;
      id_instr   <= 32'h0;
      id_ext_sel <= EXT_NONE;
    end else if (branch_taken) begin
      pc       <= branch_target & ~64'h3;
      id_valid <= 1'b0;
      case (state)
        S_REQ:   if (fetch_go) state <= S_DROP;
        S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (fetch_go) begin
            fetch_pc <= pc;
            pc       <= pc + 64'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rvalid) state <= S_REQ;
        S_DROP:  if (imem_rvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
      if (load) begin
        id_valid   <= 1'b1;
        id_pc      <= fetch_pc;
        id_instr   <= imem_rdata;
        id_ext_sel <= pre_ext;
      end else if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [1:0]  id_ext_sel;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_ext_sel    (id_ext_sel),
    .dbg_state     (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // The model tracks the fetch as a transaction: is a response owed
  // (busy), is it already known to be stale, which address it was for,
  // and what the IF/ID slot holds.
  logic [63:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic [63:0] m_fpc;
  logic        m_valid;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic [1:0]  m_ext;

  function automatic logic [1:0] ref_ext(input logic [31:0] w);
    if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) return 2'b00;
    if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) return 2'b01;
    if (w[31:26] == 6'h05) return 2'b10;
    return 2'b11;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] tbl [8];
    tbl = '{32'hF8400000, 32'hF8000000, 32'hB4000000, 32'hB5000000,
            32'h14000000, 32'h8B020020, 32'h94000000, 32'hD65F0000};
    return tbl[a[4:2]] | {16'h0, a[17:2]};
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_busy = 1'b0; m_stale = 1'b0; m_fpc = 64'h0;
    m_valid = 1'b0; m_ipc = 64'h0; m_instr = 32'h0; m_ext = 2'b11;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic       exp_req;
    logic [1:0] exp_st;
    exp_req = !m_busy && (!m_valid || id_ready);
    exp_st  = m_busy ? (m_stale ? S_DROP : S_WAIT) : S_REQ;
    chk("imem_req",   64'(imem_req),   64'(exp_req));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("id_valid",   64'(id_valid),   64'(m_valid));
    chk("id_pc",      id_pc,           m_ipc);
    chk("id_instr",   64'(id_instr),   64'(m_instr));
    chk("id_ext_sel", 64'(id_ext_sel), 64'(m_ext));
    chk("state",      64'(dbg_state),  64'(exp_st));
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    logic exp_req, granted, load;
    exp_req = !m_busy && (!m_valid || id_ready);
    granted = 1'b0;
    load    = 1'b0;
    if (!m_busy) begin
      if (exp_req && imem_gnt) begin
        granted = 1'b1;
        m_busy  = 1'b1;
        m_stale = branch_taken;
        m_fpc   = m_pc;
      end
    end else if (imem_rvalid) begin
      load    = !m_stale && !branch_taken;
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else if (branch_taken) begin
      m_stale = 1'b1;
    end
    if (branch_taken)      m_pc = {branch_target[63:2], 2'b00};
    else if (granted)      m_pc = m_pc + 64'd4;
    if (branch_taken) begin
      m_valid = 1'b0;
    end else if (load) begin
      m_valid = 1'b1;
      m_ipc   = m_fpc;
      m_instr = imem_rdata;
      m_ext   = ref_ext(imem_rdata);
    end else if (m_valid && id_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic br, input logic [63:0] tgt);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    id_ready = rdy; branch_taken = br; branch_target = tgt;
    #1;
    compare_outputs();
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] words [4];
  logic        mem_pending;
  int          mem_cnt;
  logic [63:0] mem_addr;
  logic        g, rv, rdy, br;
  logic [31:0] rd;
  logic [63:0] tgt;

  initial begin
    words = '{32'hB4000040, 32'h14000003, 32'h8B020020, 32'hF8000000};

    // Model pins: hand-derived formats.
    chk("ref_ext_ldur", 64'(ref_ext(32'hF8400000)), 64'd0);
    chk("ref_ext_cbnz", 64'(ref_ext(32'hB5000001)), 64'd1);
    chk("ref_ext_b",    64'(ref_ext(32'h17FFFFFF)), 64'd2);
    chk("ref_ext_bl",   64'(ref_ext(32'h94000001)), 64'd3);

    // 1: reset values, then a single fetch from a 1-cycle memory.
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_ext", 64'(id_ext_sel), 64'd3);
    chk("rst_addr", imem_addr, 64'h0);
    do_reset();
    tick(1, 0, 32'h0, 1, 0, 64'h0);
    tick(0, 1, 32'hF8400000, 1, 0, 64'h0);
    after_edge();
    chk("t1_valid", 64'(id_valid), 64'd1);
    chk("t1_pc", id_pc, 64'h0);
    chk("t1_instr", 64'(id_instr), 64'hF8400000);
    chk("t1_ext", 64'(id_ext_sel), 64'd0);
    chk("t1_addr", imem_addr, 64'h4);

    // 2: stream of four fetches with decode always ready.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 32'h0, 1, 0, 64'h0);
      tick(0, 1, words[i], 1, 0, 64'h0);
      after_edge();
      chk("t2_ext", 64'(id_ext_sel), 64'(i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : 0));
      chk("t2_pc", id_pc, 64'(4 * i));
    end

    // 3: stall five cycles, then release.
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 32'h0, 0, 0, 64'h0);
      chk("t3_stall_req", 64'(imem_req), 64'd0);
      chk("t3_stall_instr", 64'(id_instr), 64'hF8000000);
      chk("t3_stall_pc", id_pc, 64'hC);
    end
    tick(0, 0, 32'h0, 1, 0, 64'h0);
    after_edge();
    chk("t3_consumed", 64'(id_valid), 64'd0);
    chk("t3_next_req", 64'(imem_req), 64'd1);
    chk("t3_next_addr", imem_addr, 64'h10);

    // 4: redirect while waiting, response two cycles later is discarded.
    tick(1, 0, 32'h0, 1, 0, 64'h0);
    tick(0, 0, 32'h0, 1, 1, 64'h103);
    tick(0, 0, 32'h0, 1, 0, 64'h0);
    tick(0, 1, 32'hF8400000, 1, 0, 64'h0);
    after_edge();
    chk("t4_valid", 64'(id_valid), 64'd0);
    chk("t4_addr", imem_addr, 64'h100);
    chk("t4_state", 64'(dbg_state), 64'(S_REQ));

    // 5: redirect coincident with a grant to address 8, then with rvalid.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 32'h0, 1, 0, 64'h0);
      tick(0, 1, 32'h8B020020, 1, 0, 64'h0);
    end
    tick(1, 0, 32'h0, 1, 1, 64'h200);
    chk("t5_req", 64'(imem_req), 64'd1);
    chk("t5_req_addr", imem_addr, 64'h8);
    after_edge();
    chk("t5_drop_state", 64'(dbg_state), 64'(S_DROP));
    chk("t5_flush", 64'(id_valid), 64'd0);
    tick(0, 1, 32'hF8400000, 1, 0, 64'h0);
    after_edge();
    chk("t5_stale_dropped", 64'(id_valid), 64'd0);
    chk("t5_target_addr", imem_addr, 64'h200);
    tick(1, 0, 32'h0, 1, 0, 64'h0);
    tick(0, 1, 32'hF8400000, 1, 1, 64'h300);
    after_edge();
    chk("t5_coinc_valid", 64'(id_valid), 64'd0);
    chk("t5_coinc_state", 64'(dbg_state), 64'(S_REQ));
    chk("t5_coinc_addr", imem_addr, 64'h300);

    // 6: PC wrap, then asynchronous reset in the middle of a fetch.
    tick(0, 0, 32'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(1, 0, 32'h0, 1, 0, 64'h0);
    tick(0, 1, 32'hF8400000, 0, 0, 64'h0);
    tick(1, 0, 32'h0, 1, 0, 64'h0);
    after_edge();
    chk("t6_wrap_addr", imem_addr, 64'h0);
    chk("t6_wait_state", 64'(dbg_state), 64'(S_WAIT));
    chk("t6_held_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", 64'(dbg_state), 64'(S_REQ));
    chk("t6_async_req", 64'(imem_req), 64'd0);
    chk("t6_async_pc", id_pc, 64'h0);
    chk("t6_async_instr", 64'(id_instr), 64'h0);
    chk("t6_async_ext", 64'(id_ext_sel), 64'd3);
    do_reset();

    // Randomized traffic: variable-latency memory, random stalls/redirects.
    mem_pending = 1'b0;
    mem_cnt = 0;
    mem_addr = 64'h0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        mem_pending = 1'b0;
      end
      rv = 1'b0;
      rd = $urandom;
      if (mem_pending) begin
        if (mem_cnt == 0) begin
          rv = 1'b1;
          rd = mem_word(mem_addr);
          mem_pending = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else begin
        rv = ($urandom_range(0, 9) == 0);
      end
      g   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 15) == 0);
      tgt = {$urandom, $urandom};
      tick(g, rv, rd, rdy, br, tgt);
      if (imem_req && imem_gnt) begin
        mem_pending = 1'b1;
        mem_addr    = imem_addr;
        mem_cnt     = $urandom_range(0, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
